int32_to_ieee754_seq: RTL and testbench
=======================================

Name: int32_to_ieee754_seq

Overview:
Sequential encoder that converts a 32-bit integer (signed or unsigned) into an IEEE-754 single-precision word. It produces the float operands consumed by the add/sub/mul/div datapath; that datapath handles float-to-float arithmetic, and this block handles integer-to-float. Normalization is iterative, using a leading-zero shift loop FSM. Valid/ready handshake on both sides; one conversion in flight at a time.

Parameters:
TRUNCATE, 0, rounding mode: 0 = round-to-nearest-even, 1 = truncate toward zero.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word available
in_ready  output  1  block can accept an input
in_data  input  32  integer operand
in_signed  input  1  1 = in_data is two's complement; 0 = unsigned
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts result
out_data  output  32  IEEE-754 single result {sign, exp[7:0], frac[22:0]}
out_inexact  output  1  result differs from the exact integer value

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_inexact=0; internal magnitude/exponent registers cleared.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - sign = in_signed & in_data[31].
    - mag = sign ? (~in_data + 1) : in_data, 32-bit. For 0x80000000 signed, mag = 0x80000000.
    - exp = 8'd158 (127+31).
  - mag==0 → go to DONE with out_data=0x00000000, inexact=0.
  - Otherwise → NORM.
  - in_ready=0 in every state other than IDLE.
- NORM:
  - If mag[31]==0: mag <= mag<<1, exp <= exp-1, stay in NORM.
  - Otherwise → ROUND.
  - Cycle count equals the leading-zero count of mag, range 0..31. For example, input 1 takes 31 shift cycles.
- ROUND (1 cycle), with frac = mag[30:8], guard = mag[7], sticky = |mag[6:0]:
  - inexact = guard|sticky.
  - If TRUNCATE=0: round up when guard & (sticky | frac[0]).
  - If TRUNCATE=1: never round up.
  - Round up adds 1 to a 24-bit {1,frac}. On carry out (all ones), frac=0 and exp=exp+1. The maximum exp reached is 159, so overflow to infinity is impossible.
  - out_data <= {sign, exp, frac}; → DONE.
- DONE:
  - out_valid=1.
  - out_data and out_inexact are held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, → IDLE.
  - No bypass: a new input can be accepted at the earliest in the cycle after the handshake completes.
- Latency from accept to out_valid: 1 cycle for zero input; lzc+2 cycles otherwise. Maximum 33 cycles.
- in_data/in_signed are sampled only at accept. Later changes have no effect.
- Reset asserted mid-conversion aborts it immediately. No out_valid pulse follows; the block returns to IDLE.
- No denormal, NaN or infinity outputs are possible. -0 is never produced (zero always encodes as 0x00000000).

Optional Feature:
Macro FAST_NORM_EN.
- Defined: NORM lasts exactly 1 cycle. A combinational priority encoder computes lzc; mag <= mag<<lzc and exp <= 158-lzc. Latency is fixed at 3 cycles for nonzero input.
- Undefined: 1-bit-per-cycle loop as specified above.
- Results and the inexact flag are bit-identical in both builds.

Test Plan:
- Unsigned 1 → 0x3F800000, inexact=0; out_valid 33 cycles after accept (3 with FAST_NORM_EN).
- Signed 0xFFFFFFFF (-1) → 0xBF800000. Signed 0x80000000 → 0xCF000000, inexact=0.
- Zero (signed or unsigned) → 0x00000000, inexact=0; out_valid the cycle after accept.
- Unsigned 0x01000001 → 0x4B800000, inexact=1 (tie, rounds to even). Unsigned 0x01000003 → 0x4B800002. Unsigned 0xFFFFFFFF → 0x4F800000, inexact=1 (mantissa carry bumps exp to 159). Same inputs with TRUNCATE=1 → 0x4B800000, 0x4B800001, 0x4F7FFFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Output stays stable and in_ready=0; in_valid pulses during this window are ignored. After out_ready=1, in_ready=1 on the following cycle.
- Assert rst during NORM (input 0x00000001, 5 cycles after accept) → all outputs return to reset values asynchronously and no out_valid follows. The next conversion of 0x00000010 → 0x41800000.

Source files
------------

// File: rtl/int32_to_ieee754_seq.sv
// Sequential int32 (signed/unsigned) to IEEE-754 single encoder, valid/ready on both sides.
// Build macro FAST_NORM_EN selects a one-cycle priority-encoder normalise instead of the shift loop.
module int32_to_ieee754_seq #(
   parameter logic TRUNCATE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_inexact
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic [31:0] out_data_q, out_data_d;
   logic        inexact_q, inexact_d;

   logic        in_sign;
   logic [31:0] in_mag;
   logic        guard, sticky, rnd_up;
   logic [24:0] sum;
   logic [22:0] frac_r;
   logic [7:0]  exp_r;

   assign in_sign = in_signed & in_data[31];
   assign in_mag  = in_sign ? (~in_data + 32'd1) : in_data;

   // mag_q[31] is the hidden one, so the 24-bit significand is mag_q[31:8]
   assign guard  = mag_q[7];
   assign sticky = |mag_q[6:0];
   assign rnd_up = ~TRUNCATE & guard & (sticky | mag_q[8]);
   assign sum    = {1'b0, mag_q[31:8]} + {24'd0, rnd_up};
   assign frac_r = sum[24] ? sum[23:1] : sum[22:0];
   assign exp_r  = exp_q + {7'd0, sum[24]};

`ifdef FAST_NORM_EN
   logic [4:0] lzc;

   always_comb begin
      lzc = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (mag_q[i]) lzc = 5'(31 - i);
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      exp_d      = exp_q;
      sign_d     = sign_q;
      out_data_d = out_data_q;
      inexact_d  = inexact_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d     = in_sign;
               mag_d      = in_mag;
               exp_d      = 8'd158;
               out_data_d = 32'd0;
               inexact_d  = 1'b0;
               if (in_mag == 32'd0) begin
                  state_d = DONE;
               end else begin
`ifdef FAST_NORM_EN
                  state_d = NORM;
`else
                  state_d = in_mag[31] ? ROUND : NORM;
`endif
               end
            end
         end
         NORM: begin
`ifdef FAST_NORM_EN
            mag_d   = mag_q << lzc;
            exp_d   = 8'd158 - {3'd0, lzc};
            state_d = ROUND;
`else
            // leave as soon as the shifted value is normalised
            mag_d = mag_q << 1;
            exp_d = exp_q - 8'd1;
            if (mag_q[30]) state_d = ROUND;
`endif
         end
         ROUND: begin
            out_data_d = {sign_q, exp_r, frac_r};
            inexact_d  = guard | sticky;
            state_d    = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mag_q      <= 32'd0;
         exp_q      <= 8'd0;
         sign_q     <= 1'b0;
         out_data_q <= 32'd0;
         inexact_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         exp_q      <= exp_d;
         sign_q     <= sign_d;
         out_data_q <= out_data_d;
         inexact_q  <= inexact_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_data    = out_data_q;
   assign out_inexact = inexact_q;

endmodule

// File: tb/tb_int32_to_ieee754_seq.sv
// Bench for int32_to_ieee754_seq: RNE and truncating instances driven in lockstep,
// checked against an arithmetic reference model and directed constants.
module tb_int32_to_ieee754_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_signed = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready0, out_valid0, inexact0;
   logic        in_ready1, out_valid1, inexact1;
   logic [31:0] out_data0, out_data1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   int32_to_ieee754_seq #(.TRUNCATE(1'b0)) u_rne (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_signed(in_signed),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_inexact(inexact0)
   );

   int32_to_ieee754_seq #(.TRUNCATE(1'b1)) u_trc (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_signed(in_signed),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_inexact(inexact1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Returns {inexact, word} from plain integer arithmetic
   function automatic logic [32:0] model(input logic [31:0] d,
                                         input logic sg, input bit trunc);
      longint v, q, rem, half;
      int p, e, sh;
      logic s, inx;
      logic [31:0] w;
      s = sg & d[31];
      v = s ? (64'd4294967296 - longint'(d)) : longint'(d);
      if (v == 0) return 33'd0;
      p = 0;
      for (int i = 0; i < 33; i++) if (((v >> i) & 1) == 1) p = i;
      e = 127 + p;
      inx = 1'b0;
      if (p <= 23) begin
         q = v << (23 - p);
      end else begin
         sh = p - 23;
         q = v >> sh;
         rem = v & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         inx = (rem != 0);
         if (!trunc && (rem > half || (rem == half && q[0]))) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      w = {s, 8'(e), 23'(q)};
      return {inx, w};
   endfunction

   function automatic int lat(input logic [31:0] d, input logic sg);
      logic [31:0] m;
      int p;
      m = (sg & d[31]) ? (32'd0 - d) : d;
      if (m == 0) return 1;
`ifdef FAST_NORM_EN
      return 3;
`else
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      return (31 - p) + 2;
`endif
   endfunction

   // Launches one conversion, waits for out_valid, checks both instances.
   task automatic convert(input string tag, input logic [31:0] d,
                          input logic sg, input logic [31:0] e0,
                          input logic [31:0] e1, input logic ex0,
                          input logic ex1, input int elat);
      int cnt;
      in_data   = d;
      in_signed = sg;
      in_valid  = 1'b1;
      chk({tag, "/rdy"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_signed = 1'($urandom);
      cnt = 1;
      while (!out_valid0 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({tag, "/lat"}, 32'(cnt), 32'(elat));
      chk({tag, "/vld1"}, {31'd0, out_valid1}, 32'd1);
      chk({tag, "/d0"}, out_data0, e0);
      chk({tag, "/d1"}, out_data1, e1);
      chk({tag, "/x0"}, {31'd0, inexact0}, {31'd0, ex0});
      chk({tag, "/x1"}, {31'd0, inexact1}, {31'd0, ex1});
      if (out_ready) begin
         @(posedge clk);
         #1;
         chk({tag, "/idle"}, {30'd0, out_valid0, in_ready0}, 32'd1);
      end
   endtask

   task automatic conv_model(input string tag, input logic [31:0] d,
                             input logic sg);
      logic [32:0] r0, r1;
      r0 = model(d, sg, 1'b0);
      r1 = model(d, sg, 1'b1);
      convert(tag, d, sg, r0[31:0], r1[31:0], r0[32], r1[32], lat(d, sg));
   endtask

   initial begin
      logic [31:0] held0, held1;
      int vcount;
`ifdef FAST_NORM_EN
      int lat_one = 3;
`else
      int lat_one = 33;
`endif
      rst = 1'b1;
      #12;
      chk("rst/out", {out_valid0, inexact0, in_ready0}, 32'd1);
      chk("rst/data", out_data0, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      convert("u1", 32'h1, 1'b0, 32'h3F800000, 32'h3F800000, 0, 0, lat_one);
      convert("sm1", 32'hFFFFFFFF, 1'b1, 32'hBF800000, 32'hBF800000,
              0, 0, lat(32'hFFFFFFFF, 1'b1));
      convert("smin", 32'h80000000, 1'b1, 32'hCF000000, 32'hCF000000,
              0, 0, lat(32'h80000000, 1'b1));
      convert("z_s", 32'h0, 1'b1, 32'h0, 32'h0, 0, 0, 1);
      convert("z_u", 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 1);
      convert("tie", 32'h01000001, 1'b0, 32'h4B800000, 32'h4B800000,
              1, 1, lat(32'h01000001, 1'b0));
      convert("rup", 32'h01000003, 1'b0, 32'h4B800002, 32'h4B800001,
              1, 1, lat(32'h01000003, 1'b0));
      convert("umax", 32'hFFFFFFFF, 1'b0, 32'h4F800000, 32'h4F7FFFFF,
              1, 1, lat(32'hFFFFFFFF, 1'b0));

      // Backpressure: result held, new inputs refused
      out_ready = 1'b0;
      conv_model("bp", 32'h00ABCDEF, 1'b0);
      held0 = out_data0;
      held1 = out_data1;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = $urandom;
         @(posedge clk);
         #1;
         chk("bp/vld", {31'd0, out_valid0}, 32'd1);
         chk("bp/rdy", {31'd0, in_ready0 | in_ready1}, 32'd0);
         chk("bp/d0", out_data0, held0);
         chk("bp/d1", out_data1, held1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp/rel", {30'd0, out_valid0, in_ready0}, 32'd1);
      @(posedge clk);
      #1;
      chk("bp/stay", {30'd0, out_valid0, in_ready0}, 32'd1);

      // Reset mid-normalisation aborts without a result
      in_data  = 32'h1;
      in_signed = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("ar/out", {out_valid0, inexact0, in_ready0}, 32'd1);
      chk("ar/data", out_data0, 32'd0);
      #2;
      rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid0 || out_valid1) vcount++;
      end
      chk("ar/novld", 32'(vcount), 32'd0);
      convert("ar/next", 32'h10, 1'b0, 32'h41800000, 32'h41800000,
              0, 0, lat(32'h10, 1'b0));

      for (int i = 0; i < 200; i++) begin
         logic [31:0] d;
         d = $urandom >> $urandom_range(0, 31);
         if (i % 3 == 0) d = ~d;
         conv_model($sformatf("rnd%0d", i), d, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
